// File: rtl/pipe_ctrl_chain.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_chain
//
// Parametrised chain of pipeline registers that carries the decoded control
// word, funct word, PC and a valid bit from decode (stage 0 = ID/EX) through
// the back-end stages (stage STAGES-1 = MEM/WB) of the RV32I core.
//
// Each stage supports an independent stall (hold) and flush (kill). When a
// stage advances while the stage feeding it is held, a bubble is inserted.
// An all-zero control word deasserts every write enable, so a bubble has no
// architectural effect. The bubble's PC still follows the upstream stage so
// that debug traces stay readable.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid      stage-0 input is a real instruction
//   in_cw         control word entering stage 0
//   in_fw         funct word entering stage 0
//   in_pc         PC entering stage 0
//   stall         bit i holds stage i this cycle
//   flush         bit i empties stage i this cycle (wins over stall)
//   stage_valid   valid bit per stage
//   stage_cw      control word per stage, stage i at [i*CW_W +: CW_W]
//   stage_fw      funct word per stage, stage i at [i*FW_W +: FW_W]
//   stage_pc      PC per stage, stage i at [i*32 +: 32]
//   bubble_cnt    saturating count of cycles with at least one bubble
//   flush_cnt     saturating count of cycles that flushed a valid stage
//   protocol_err  sticky flag: a non-prefix stall pattern was seen
// ---------------------------------------------------------------------------
module pipe_ctrl_chain #(
    parameter int STAGES = 4,
    parameter int CW_W   = 32,
    parameter int FW_W   = 18,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CW_W-1:0]          in_cw,
    input  logic [FW_W-1:0]          in_fw,
    input  logic [31:0]              in_pc,
    input  logic [STAGES-1:0]        stall,
    input  logic [STAGES-1:0]        flush,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*CW_W-1:0]   stage_cw,
    output logic [STAGES*FW_W-1:0]   stage_fw,
    output logic [STAGES*32-1:0]     stage_pc,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         flush_cnt,
    output logic                     protocol_err
);

    // -----------------------------------------------------------------------
    // Stage storage
    // -----------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [CW_W-1:0]   cw_q [STAGES];
    logic [CW_W-1:0]   cw_d [STAGES];
    logic [FW_W-1:0]   fw_q [STAGES];
    logic [FW_W-1:0]   fw_d [STAGES];
    logic [31:0]       pc_q [STAGES];
    logic [31:0]       pc_d [STAGES];

    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic              protocol_err_q;

    // -----------------------------------------------------------------------
    // Per-stage decisions as bit masks
    //
    // stall_up[i] is the stall of the stage feeding stage i; stage 0 is fed
    // from the decode inputs, which are never "held" from this block's point
    // of view, hence the zero shifted into bit 0.
    // -----------------------------------------------------------------------
    logic [STAGES-1:0] stall_up;
    logic [STAGES-1:0] take_flush;
    logic [STAGES-1:0] take_hold;
    logic [STAGES-1:0] take_bubble;
    logic [STAGES-1:0] lost_data;
    logic [STAGES-1:0] flushed_valid;

    assign stall_up = {stall[STAGES-2:0], 1'b0};

    assign take_flush  = flush;
    assign take_hold   = ~flush & stall;
    // Bubble only possible for i>0: stall_up[0] is always 0.
    assign take_bubble = ~flush & ~stall & stall_up;

    // Upstream advancing into a held stage would overwrite it. Stage 0 has no
    // upstream stage; a flushed stage has nothing to lose.
    assign lost_data     = stall & ~stall_up & ~flush & {{(STAGES-1){1'b1}}, 1'b0};
    assign flushed_valid = flush & valid_q;

    // -----------------------------------------------------------------------
    // Next-state datapath
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            cw_d[i] = cw_q[i];
            fw_d[i] = fw_q[i];
            pc_d[i] = pc_q[i];
        end

        for (int i = 0; i < STAGES; i++) begin
            if (take_flush[i]) begin
                valid_d[i] = 1'b0;
                cw_d[i]    = '0;
                fw_d[i]    = '0;
                pc_d[i]    = '0;
            end else if (take_hold[i]) begin
                valid_d[i] = valid_q[i];
            end else if (i == 0) begin
                // An invalid slot must never carry write enables.
                valid_d[i] = in_valid;
                cw_d[i]    = in_valid ? in_cw : '0;
                fw_d[i]    = in_fw;
                pc_d[i]    = in_pc;
            end else if (take_bubble[i]) begin
                valid_d[i] = 1'b0;
                cw_d[i]    = '0;
                fw_d[i]    = '0;
                pc_d[i]    = pc_q[i-1];
            end else begin
                valid_d[i] = valid_q[i-1];
                cw_d[i]    = cw_q[i-1];
                fw_d[i]    = fw_q[i-1];
                pc_d[i]    = pc_q[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                cw_q[i] <= '0;
                fw_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                cw_q[i] <= cw_d[i];
                fw_q[i] <= fw_d[i];
                pc_q[i] <= pc_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters (saturating) and sticky protocol error
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q   <= '0;
            flush_cnt_q    <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            if ((|take_bubble) && (bubble_cnt_q != {CNT_W{1'b1}})) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
            if ((|flushed_valid) && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if (|lost_data) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output packing
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign stage_cw[g*CW_W +: CW_W] = cw_q[g];
        assign stage_fw[g*FW_W +: FW_W] = fw_q[g];
        assign stage_pc[g*32 +: 32]     = pc_q[g];
    end

    assign stage_valid  = valid_q;
    assign bubble_cnt   = bubble_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_chain
//
// Directed bench for pipe_ctrl_chain with STAGES=4 and CNT_W=4 (small counter
// width so saturation is reachable quickly). Each instruction's cw/fw are
// derived from its PC so every stage's contents can be predicted by hand.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_chain;

    localparam int STAGES = 4;
    localparam int CW_W   = 32;
    localparam int FW_W   = 18;
    localparam int CNT_W  = 4;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [CW_W-1:0]        in_cw;
    logic [FW_W-1:0]        in_fw;
    logic [31:0]            in_pc;
    logic [STAGES-1:0]      stall;
    logic [STAGES-1:0]      flush;
    logic [STAGES-1:0]      stage_valid;
    logic [STAGES*CW_W-1:0] stage_cw;
    logic [STAGES*FW_W-1:0] stage_fw;
    logic [STAGES*32-1:0]   stage_pc;
    logic [CNT_W-1:0]       bubble_cnt;
    logic [CNT_W-1:0]       flush_cnt;
    logic                   protocol_err;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl_chain #(
        .STAGES(STAGES),
        .CW_W  (CW_W),
        .FW_W  (FW_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_cw       (in_cw),
        .in_fw       (in_fw),
        .in_pc       (in_pc),
        .stall       (stall),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stage_cw    (stage_cw),
        .stage_fw    (stage_fw),
        .stage_pc    (stage_pc),
        .bubble_cnt  (bubble_cnt),
        .flush_cnt   (flush_cnt),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW_W-1:0] cw_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic logic [FW_W-1:0] fw_of(input logic [31:0] pc);
        return pc[FW_W-1:0] ^ 18'h2AAAA;
    endfunction

    function automatic logic [31:0] spc(input int i);
        return stage_pc[i*32 +: 32];
    endfunction

    function automatic logic [CW_W-1:0] scw(input int i);
        return stage_cw[i*CW_W +: CW_W];
    endfunction

    function automatic logic [FW_W-1:0] sfw(input int i);
        return stage_fw[i*FW_W +: FW_W];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl);
        in_valid = v;
        in_pc    = pc;
        in_cw    = cw_of(pc);
        in_fw    = fw_of(pc);
        stall    = st;
        flush    = fl;
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(stage_valid), 64'h0);
        for (int i = 0; i < STAGES; i++) begin
            check($sformatf("%s_cw%0d", tag, i), 64'(scw(i)), 64'h0);
            check($sformatf("%s_fw%0d", tag, i), 64'(sfw(i)), 64'h0);
            check($sformatf("%s_pc%0d", tag, i), 64'(spc(i)), 64'h0);
        end
        check({tag, "_bcnt"}, 64'(bubble_cnt), 64'h0);
        check({tag, "_fcnt"}, 64'(flush_cnt), 64'h0);
        check({tag, "_err"},  64'(protocol_err), 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 32'h0000_0ABC, 4'b0000, 4'b0000);
        step(1);
        check_all_zero("reset");

        // Stream four instructions, no stalls.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 4'b0000, 4'b0000);
            step(1);
        end
        check("stream_s3_pc",  64'(spc(3)), 64'h100);
        check("stream_s3_v",   64'(stage_valid[3]), 64'h1);
        check("stream_s3_cw",  64'(scw(3)), 64'(cw_of(32'h100)));
        check("stream_s3_fw",  64'(sfw(3)), 64'(fw_of(32'h100)));
        check("stream_s0_pc",  64'(spc(0)), 64'h10C);
        check("stream_valid",  64'(stage_valid), 64'hF);
        check("stream_bcnt",   64'(bubble_cnt), 64'h0);
        check("stream_fcnt",   64'(flush_cnt), 64'h0);

        // Load-use bubble: hold stage 0 (0x10C), bubble into stage 1.
        drive(1'b1, 32'h110, 4'b0001, 4'b0000);
        step(1);
        check("lu_s0_pc",   64'(spc(0)), 64'h10C);
        check("lu_s0_v",    64'(stage_valid[0]), 64'h1);
        check("lu_s1_v",    64'(stage_valid[1]), 64'h0);
        check("lu_s1_cw",   64'(scw(1)), 64'h0);
        check("lu_s1_fw",   64'(sfw(1)), 64'h0);
        check("lu_s1_pc",   64'(spc(1)), 64'h10C);
        check("lu_s2_pc",   64'(spc(2)), 64'h108);
        check("lu_s3_pc",   64'(spc(3)), 64'h104);
        check("lu_bcnt",    64'(bubble_cnt), 64'h1);
        check("lu_err",     64'(protocol_err), 64'h0);

        // Release: bubble moves on, stage 0 takes new input.
        drive(1'b1, 32'h110, 4'b0000, 4'b0000);
        step(1);
        check("rel_s0_pc",  64'(spc(0)), 64'h110);
        check("rel_s1_pc",  64'(spc(1)), 64'h10C);
        check("rel_valid",  64'(stage_valid), 64'b1011);
        check("rel_s3_pc",  64'(spc(3)), 64'h108);
        check("rel_bcnt",   64'(bubble_cnt), 64'h1);

        // Global stall for 10 cycles: nothing moves.
        drive(1'b1, 32'h114, 4'b1111, 4'b0000);
        step(10);
        check("gs_valid",   64'(stage_valid), 64'b1011);
        check("gs_s0_pc",   64'(spc(0)), 64'h110);
        check("gs_s1_cw",   64'(scw(1)), 64'(cw_of(32'h10C)));
        check("gs_s2_pc",   64'(spc(2)), 64'h10C);
        check("gs_s3_pc",   64'(spc(3)), 64'h108);
        check("gs_bcnt",    64'(bubble_cnt), 64'h1);
        check("gs_err",     64'(protocol_err), 64'h0);

        // Branch flush of stages 0-1 (both valid).
        drive(1'b1, 32'h114, 4'b0000, 4'b0011);
        step(1);
        check("fl_valid",   64'(stage_valid), 64'b0100);
        check("fl_s0_cw",   64'(scw(0)), 64'h0);
        check("fl_s1_cw",   64'(scw(1)), 64'h0);
        check("fl_s0_pc",   64'(spc(0)), 64'h0);
        check("fl_s2_pc",   64'(spc(2)), 64'h10C);
        check("fl_s2_cw",   64'(scw(2)), 64'(cw_of(32'h10C)));
        check("fl_s3_pc",   64'(spc(3)), 64'h10C);
        check("fl_fcnt",    64'(flush_cnt), 64'h1);
        check("fl_bcnt",    64'(bubble_cnt), 64'h1);

        // Flush again with stages 0-1 already empty: counter unchanged.
        step(1);
        check("fl2_fcnt",   64'(flush_cnt), 64'h1);
        check("fl2_s3_pc",  64'(spc(3)), 64'h10C);
        check("fl2_s3_v",   64'(stage_valid[3]), 64'h1);

        // Illegal stall pattern: stage 2 held while stage 1 advances.
        drive(1'b1, 32'h120, 4'b0100, 4'b0000);
        step(1);
        check("ill_err",    64'(protocol_err), 64'h1);
        check("ill_s0_pc",  64'(spc(0)), 64'h120);
        check("ill_s3_v",   64'(stage_valid[3]), 64'h0);
        check("ill_bcnt",   64'(bubble_cnt), 64'h2);
        drive(1'b1, 32'h124, 4'b0000, 4'b0000);
        step(1);
        check("ill_sticky", 64'(protocol_err), 64'h1);
        check("ill_s1_pc",  64'(spc(1)), 64'h120);

        // Same pattern with stage 2 flushed: no error.
        rst = 1'b1;
        step(1);
        check("rst2_err",   64'(protocol_err), 64'h0);
        check("rst2_bcnt",  64'(bubble_cnt), 64'h0);
        rst = 1'b0;
        drive(1'b1, 32'h128, 4'b0100, 4'b0100);
        step(1);
        check("illf_err",   64'(protocol_err), 64'h0);
        check("illf_bcnt",  64'(bubble_cnt), 64'h1);
        check("illf_s0_pc", 64'(spc(0)), 64'h128);

        // Saturation: 20 bubble cycles on stage 1 starting from count 1.
        drive(1'b1, 32'h12C, 4'b0001, 4'b0000);
        step(13);
        check("sat_mid",    64'(bubble_cnt), 64'hE);
        step(1);
        check("sat_full",   64'(bubble_cnt), 64'hF);
        step(6);
        check("sat_hold",   64'(bubble_cnt), 64'hF);
        check("sat_err",    64'(protocol_err), 64'h0);

        // Reset during a global stall discards everything.
        drive(1'b1, 32'h130, 4'b1111, 4'b0000);
        rst = 1'b1;
        step(1);
        check_all_zero("rst_gs");

        // Invalid input: cw forced to zero, fw and pc still captured.
        rst = 1'b0;
        drive(1'b0, 32'h200, 4'b0000, 4'b0000);
        step(1);
        check("inv_s0_v",   64'(stage_valid[0]), 64'h0);
        check("inv_s0_cw",  64'(scw(0)), 64'h0);
        check("inv_s0_fw",  64'(sfw(0)), 64'(fw_of(32'h200)));
        check("inv_s0_pc",  64'(spc(0)), 64'h200);
        check("inv_bcnt",   64'(bubble_cnt), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
